div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the only build-time option SHALL be the macro in Configuration.
REQ-002 The block SHALL have these ports (clock and reset first):
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- source  input  16  divisor, captured on accepted start.
- destination  input  16  dividend, captured on accepted start.
- flags_in  input  16  flags word, captured on accepted start; bit 8 = sign flag.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- result_out  output  16  quotient.
- remainder_out  output  16  remainder.
- flags_out  output  16  {flags_in[15:5], divide_error, overflow, carry, negative, zero}.
- write_flags  output  1  equals done.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-004 IDLE with start=1 SHALL latch source, destination and flags_in. If source is nonzero it SHALL go to RUN with iteration counter 0; otherwise it SHALL go to DONE.
REQ-005 RUN SHALL do one restoring shift-subtract step per cycle, MSB first: 16 cycles, counter 0..15, then go to DONE.
REQ-006 DONE SHALL last exactly one cycle, with done=1 and write_flags=1, then return to IDLE.
REQ-007 Latency: start accepted at edge N gives done=1 in cycle N+17 for nonzero divisor and N+1 for zero divisor.
REQ-008 start SHALL be ignored in RUN and DONE; the latched operands SHALL be unaffected by input changes after capture.
REQ-009 result_out, remainder_out and flags_out SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-010 Unsigned mode: quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor, both 16-bit exact.
REQ-011 Divisor 0: quotient 0x0000, remainder = dividend, divide_error=1, zero=1, negative=0, carry=0, overflow=0.
REQ-012 zero SHALL be 1 when quotient==0. negative SHALL equal quotient[15]. carry SHALL be 0. overflow SHALL be 0 except as in REQ-017.
REQ-013 flags_out[15:5] SHALL equal the latched flags_in[15:5].

Reset
REQ-014 reset_n low SHALL asynchronously force IDLE, counter 0, busy=0, done=0, write_flags=0, result_out=0, remainder_out=0, flags_out=0 and all latched operands to 0.
REQ-015 Reset during RUN or DONE SHALL abort the operation with no done pulse. The first start after release SHALL behave as from power-up.

Configuration
REQ-016 Macro DIV_SIGNED_EN. When undefined, flags_in[8] SHALL be ignored and all division SHALL be unsigned.
REQ-017 When DIV_SIGNED_EN is defined and latched flags_in[8]=1:
- Operands SHALL be treated as two's complement and divided as magnitudes.
- Quotient sign SHALL be dividend XOR divisor sign; remainder sign SHALL follow the dividend (truncation toward zero).
- 0x8000 / 0xFFFF SHALL give quotient 0x8000, remainder 0x0000, overflow=1.
- Latency SHALL be unchanged.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- destination=100, source=7, start at cycle 0 -> done at cycle 17, result_out=14, remainder_out=2, flags_out[4:0]=00000.
- destination=0xFFFF, source=1 -> result_out=0xFFFF, remainder_out=0, negative=1, zero=0, done after 17 cycles.
- destination=0x1234, source=0 -> done next cycle, result_out=0, remainder_out=0x1234, flags_out[4:0]=10001.
- start held high for 40 cycles with operands changing -> exactly two completions, each using the operands present at its IDLE acceptance.
- reset_n low at RUN cycle 8 -> outputs zero immediately, no done pulse; next 100/7 gives 14 r 2.
- DIV_SIGNED_EN defined, flags_in[8]=1, 0xFFF9 / 2 -> result_out=0xFFFD, remainder_out=0xFFFF, negative=1. Same operands with flags_in[8]=0 -> result_out=0x7FFC, remainder_out=1.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: 16-bit sequential restoring divider, one quotient bit per cycle.
// IDLE accepts a request, RUN performs 16 shift-subtract steps MSB first,
// DONE presents a one-cycle completion pulse with quotient, remainder and
// an updated flags word. A zero divisor skips RUN and reports divide_error.
// Build option: define DIV_SIGNED_EN to enable two's-complement division
// when the captured flags word has bit 8 set.
module div_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] source,
  input  logic [15:0] destination,
  input  logic [15:0] flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_out,
  output logic [15:0] remainder_out,
  output logic [15:0] flags_out,
  output logic        write_flags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] divisor_q, divisor_d;     // divisor magnitude
  logic [15:0] dividend_q, dividend_d;   // dividend as captured
  logic [15:0] quo_q, quo_d;             // dividend bits shift out, quotient bits shift in
  logic [15:0] rem_q, rem_d;             // partial remainder
  logic [15:0] flags_q, flags_d;         // captured flags word
  logic        qneg_q, qneg_d;           // quotient must be negated at the end
  logic        rneg_q, rneg_d;           // remainder must be negated at the end
  logic        sgn_q, sgn_d;             // operation runs in signed mode
  logic [15:0] result_q, result_d;
  logic [15:0] remainder_q, remainder_d;
  logic [15:0] flags_out_q, flags_out_d;

  // Signed-mode selection from the live flags word at capture time.
  logic sgn_mode;
`ifdef DIV_SIGNED_EN
  assign sgn_mode = flags_in[8];
`else
  assign sgn_mode = 1'b0;
`endif

  logic        dvd_neg, dvs_neg;
  logic [15:0] dvd_mag, dvs_mag;
  assign dvd_neg = sgn_mode & destination[15];
  assign dvs_neg = sgn_mode & source[15];
  assign dvd_mag = dvd_neg ? (16'd0 - destination) : destination;
  assign dvs_mag = dvs_neg ? (16'd0 - source) : source;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  logic [16:0] shifted, diff;
  logic        fits;
  logic [15:0] rem_step, quo_step, q_fin, r_fin;
  logic        ovf_fin;
  assign shifted  = {rem_q, quo_q[15]};
  assign diff     = shifted - {1'b0, divisor_q};
  assign fits     = ~diff[16];
  assign rem_step = fits ? diff[15:0] : shifted[15:0];
  assign quo_step = {quo_q[14:0], fits};
  assign q_fin    = qneg_q ? (16'd0 - quo_step) : quo_step;
  assign r_fin    = rneg_q ? (16'd0 - rem_step) : rem_step;
  // Only 0x8000 / -1 yields a positive magnitude with bit 15 set.
  assign ovf_fin  = sgn_q & ~qneg_q & quo_step[15];

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    flags_d     = flags_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    sgn_d       = sgn_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    flags_out_d = flags_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d  = dvs_mag;
          dividend_d = destination;
          quo_d      = dvd_mag;
          rem_d      = 16'd0;
          flags_d    = flags_in;
          qneg_d     = dvd_neg ^ dvs_neg;
          rneg_d     = dvd_neg;
          sgn_d      = sgn_mode;
          cnt_d      = 4'd0;
          if (source != 16'd0) begin
            state_d = RUN;
          end else begin
            state_d     = DONE;
            result_d    = 16'd0;
            remainder_d = destination;
            flags_out_d = {flags_in[15:5], 5'b10001};
          end
        end
      end
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d     = DONE;
          result_d    = q_fin;
          remainder_d = r_fin;
          flags_out_d = {flags_q[15:5], 1'b0, ovf_fin, 1'b0, q_fin[15], (q_fin == 16'd0)};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      divisor_q   <= 16'd0;
      dividend_q  <= 16'd0;
      quo_q       <= 16'd0;
      rem_q       <= 16'd0;
      flags_q     <= 16'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      sgn_q       <= 1'b0;
      result_q    <= 16'd0;
      remainder_q <= 16'd0;
      flags_out_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      flags_q     <= flags_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      sgn_q       <= sgn_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      flags_out_q <= flags_out_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign write_flags   = done;
  assign result_out    = result_q;
  assign remainder_out = remainder_q;
  assign flags_out     = flags_out_q;

endmodule
